// File: rtl/trace_fabric_mgmt_arbiter_if.sv
// Trace-fabric management stream bundle.
// Holds the per-source ingress beats and the merged egress beat.
interface trace_fabric_mgmt_arbiter_if #(
  parameter int NUM_SRC   = 4,
  parameter int CHANNEL_W = 8
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]           in_valid;
  logic [NUM_SRC-1:0]           in_data;
  logic [NUM_SRC*CHANNEL_W-1:0] in_channel;
  logic                         out_valid;
  logic                         out_data;
  logic [CHANNEL_W-1:0]         out_channel;
  logic [SRC_W-1:0]             out_src;
  logic                         out_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_channel,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_channel,
    input  out_src
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_channel,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_channel,
    output out_src
  );
endinterface

// File: rtl/trace_fabric_mgmt_arbiter.sv
// Merges non-backpressurable management sources through per-source
// FIFOs and a round-robin scheduler into one registered output beat.
module trace_fabric_mgmt_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CHANNEL_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  trace_fabric_mgmt_arbiter_if.slave bus,
  input  logic                clr_stats,
  output logic [NUM_SRC-1:0]  overflow,
  output logic [15:0]         drop_count
);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = CHANNEL_W + 1;

  typedef logic [EW-1:0] entry_t;
  typedef enum logic {S_EMPTY, S_FULL} state_t;

  entry_t         mem [NUM_SRC][FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr [NUM_SRC];
  logic [AW-1:0]  rd_ptr [NUM_SRC];
  logic [AW:0]    count [NUM_SRC];

  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] drop;

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant;
  logic             grant_vld;
  logic             load;
  logic             take;
  entry_t           head;
  state_t           state;
  state_t           state_nx;

  logic [15:0] drop_n;
  logic [16:0] drop_sum;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      nonempty[i] = (count[i] != '0);
    end
  end

  // Walk downward so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    logic [SRC_W-1:0] sel;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      sel = SRC_W'(idx);
      if (nonempty[sel]) begin
        grant     = sel;
        grant_vld = 1'b1;
      end
    end
  end

  assign head = mem[grant][rd_ptr[grant]];

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      S_EMPTY: load = 1'b1;
      S_FULL:  load = bus.out_ready;
    endcase
    take = load && grant_vld;
    if (load) state_nx = grant_vld ? S_FULL : S_EMPTY;
  end

  // A full FIFO popped this cycle frees the slot it is written into.
  always_comb begin
    logic full;
    full = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      full    = (count[i] == (AW+1)'(FIFO_DEPTH));
      pop[i]  = take && (grant == SRC_W'(i));
      push[i] = bus.in_valid[i] && (!full || pop[i]);
      drop[i] = bus.in_valid[i] && full && !pop[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= {bus.in_data[i],
          bus.in_channel[i*CHANNEL_W +: CHANNEL_W]};
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (reset) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end else begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        unique case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_EMPTY;
      rr_ptr          <= '0;
      bus.out_data    <= 1'b0;
      bus.out_channel <= '0;
      bus.out_src     <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        bus.out_data    <= head[CHANNEL_W];
        bus.out_channel <= head[CHANNEL_W-1:0];
        bus.out_src     <= grant;
        rr_ptr <= (grant == SRC_W'(NUM_SRC - 1)) ?
                  '0 : grant + 1'b1;
      end
    end
  end

  assign bus.out_valid = (state == S_FULL);

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      drop_n = drop_n + 16'(drop[i]);
    end
    drop_sum = {1'b0, drop_count} + {1'b0, drop_n};
  end

  // Drops in the clearing cycle survive the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= '0;
      drop_count <= '0;
    end else if (clr_stats) begin
      overflow   <= drop;
      drop_count <= drop_n;
    end else begin
      overflow   <= overflow | drop;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
endmodule

// File: tb/tb_trace_fabric_mgmt_arbiter.sv
// Directed bench for trace_fabric_mgmt_arbiter.
// Inputs change and outputs are sampled 1 time unit after each edge.
module tb_trace_fabric_mgmt_arbiter;
  logic       clk;
  logic       reset;
  logic       clr_stats;
  logic [3:0] overflow;
  logic [15:0] drop_count;

  int n_checks;
  int n_errors;

  trace_fabric_mgmt_arbiter_if #(.NUM_SRC(4), .CHANNEL_W(8)) bus ();

  trace_fabric_mgmt_arbiter #(
    .NUM_SRC(4),
    .FIFO_DEPTH(4),
    .CHANNEL_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .clr_stats(clr_stats),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.in_valid   = '0;
    bus.in_data    = '0;
    bus.in_channel = '0;
  endtask

  task automatic set_src(input int s, input logic d,
                         input logic [7:0] ch);
    bus.in_valid[s]           = 1'b1;
    bus.in_data[s]            = d;
    bus.in_channel[s*8 +: 8]  = ch;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    clr_stats = 1'b0;
    clear_in();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    clr_stats = 1'b0;
    bus.out_ready = 1'b1;
    clear_in();
    tick();
    tick();
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data", 32'(bus.out_data), 0);
    check("rst_chan", 32'(bus.out_channel), 0);
    check("rst_src", 32'(bus.out_src), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_drops", 32'(drop_count), 0);
    reset = 1'b0;

    // single beat, two-cycle latency
    set_src(2, 1'b1, 8'h5A);
    tick();
    clear_in();
    check("sb_early", 32'(bus.out_valid), 0);
    tick();
    check("sb_valid", 32'(bus.out_valid), 1);
    check("sb_data", 32'(bus.out_data), 1);
    check("sb_chan", 32'(bus.out_channel), 32'h5A);
    check("sb_src", 32'(bus.out_src), 2);
    tick();
    check("sb_after", 32'(bus.out_valid), 0);

    // round robin, 3 beats from every source
    do_reset();
    for (int c = 0; c < 14; c++) begin
      clear_in();
      if (c < 3) begin
        for (int s = 0; s < 4; s++) begin
          set_src(s, 1'((s + c) % 2), 8'(s * 16 + c));
        end
      end
      tick();
      if (c >= 1 && c <= 12) begin
        int k;
        k = c - 1;
        check("rr_valid", 32'(bus.out_valid), 1);
        check("rr_src", 32'(bus.out_src), 32'(k % 4));
        check("rr_chan", 32'(bus.out_channel),
              32'((k % 4) * 16 + k / 4));
        check("rr_data", 32'(bus.out_data),
              32'(((k % 4) + k / 4) % 2));
      end
    end
    check("rr_end", 32'(bus.out_valid), 0);
    check("rr_drops", 32'(drop_count), 0);

    // backpressure hold
    do_reset();
    bus.out_ready = 1'b0;
    set_src(0, 1'b0, 8'h11);
    tick();
    clear_in();
    set_src(0, 1'b1, 8'h12);
    tick();
    clear_in();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.out_valid), 1);
      check("bp_chan", 32'(bus.out_channel), 32'h11);
      check("bp_data", 32'(bus.out_data), 0);
      check("bp_src", 32'(bus.out_src), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_next_chan", 32'(bus.out_channel), 32'h12);
    check("bp_next_data", 32'(bus.out_data), 1);
    tick();
    check("bp_end", 32'(bus.out_valid), 0);

    // overflow on src 1
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      clear_in();
      set_src(1, 1'(i % 2), 8'(8'h20 + i));
      tick();
    end
    clear_in();
    check("ovf_flags", 32'(overflow), 32'h2);
    check("ovf_drops", 32'(drop_count), 2);
    check("ovf_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("ovf_chan", 32'(bus.out_channel), 32'(32'h20 + i));
      check("ovf_src", 32'(bus.out_src), 1);
      check("ovf_data", 32'(bus.out_data), 32'(i % 2));
      tick();
    end
    check("ovf_end", 32'(bus.out_valid), 0);

    // full FIFO written and popped in the same cycle
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      clear_in();
      set_src(3, 1'b0, 8'(8'h30 + i));
      tick();
    end
    clear_in();
    check("pp_head", 32'(bus.out_channel), 32'h30);
    bus.out_ready = 1'b1;
    set_src(3, 1'b1, 8'h35);
    tick();
    clear_in();
    check("pp_drops", 32'(drop_count), 0);
    check("pp_ovf", 32'(overflow), 0);
    check("pp_chan1", 32'(bus.out_channel), 32'h31);
    for (int i = 2; i < 6; i++) begin
      tick();
      check("pp_chan", 32'(bus.out_channel), 32'(32'h30 + i));
      check("pp_valid", 32'(bus.out_valid), 1);
    end
    check("pp_last_data", 32'(bus.out_data), 1);
    tick();
    check("pp_end", 32'(bus.out_valid), 0);

    // clr_stats racing a drop
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clear_in();
      set_src(0, 1'b0, 8'(8'h40 + i));
      tick();
    end
    check("clr_pre_drops", 32'(drop_count), 1);
    check("clr_pre_ovf", 32'(overflow), 1);
    clear_in();
    set_src(0, 1'b0, 8'h46);
    tick();
    check("clr_acc_drops", 32'(drop_count), 2);
    set_src(0, 1'b0, 8'h47);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    clear_in();
    check("clr_race_drops", 32'(drop_count), 1);
    check("clr_race_ovf", 32'(overflow), 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_only_drops", 32'(drop_count), 0);
    check("clr_only_ovf", 32'(overflow), 0);

    // reset with beats queued; reset-cycle input is ignored
    check("rq_busy", 32'(bus.out_valid), 1);
    reset = 1'b1;
    set_src(3, 1'b1, 8'h77);
    tick();
    reset = 1'b0;
    clear_in();
    check("rq_valid", 32'(bus.out_valid), 0);
    check("rq_data", 32'(bus.out_data), 0);
    check("rq_chan", 32'(bus.out_channel), 0);
    check("rq_src", 32'(bus.out_src), 0);
    check("rq_ovf", 32'(overflow), 0);
    check("rq_drops", 32'(drop_count), 0);
    bus.out_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (bus.out_valid) seen++;
      end
      check("rq_no_emit", 32'(seen), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
